iq_stage_fifo: RTL and testbench
================================

// Module: iq_stage_fifo
// PURPOSE
//   Complex (I/Q) sample buffer placed between DSP stages of the radio chain.
//   Write side accepts the one-cycle Done/Iout/Qout pulse emitted by a filter stage.
//   Read side answers the in_rd_en/newDataAvailible/Iin/Qin pull protocol used by
//   filter inputs, so any stage's output can feed the next stage's input.
//   The write side has no backpressure: producers pulse regardless, so overflow is flagged, never stalled.
// PARAMETERS
//   DATA_WIDTH  32  width of each of I and Q, two's complement, passed through unmodified
//   DEPTH       16  number of complex entries; power of two, >= 2
//   ADDR_WIDTH  $clog2(DEPTH)  localparam; pointer width; count is ADDR_WIDTH+1 bits
// PORTS
//   clock      in   1             rising-edge clock
//   reset      in   1             asynchronous, active-high
//   flush      in   1             synchronous clear of contents (keeps overflow flag)
//   wr_en      in   1             producer Done pulse; push {Iin,Qin} this cycle
//   Iin        in   DATA_WIDTH    I sample to push
//   Qin        in   DATA_WIDTH    Q sample to push
//   rd_en      in   1             consumer in_rd_en; pop head if data_avail
//   Iout       out  DATA_WIDTH    head I sample (show-ahead), 0 when empty
//   Qout       out  DATA_WIDTH    head Q sample (show-ahead), 0 when empty
//   data_avail out  1             consumer newDataAvailible; = (count != 0)
//   full       out  1             count == DEPTH
//   count      out  ADDR_WIDTH+1  entries held
//   overflow   out  1             sticky: a push was dropped because full
// BEHAVIOUR
//   - Reset (async): wr_ptr=rd_ptr=0, count=0, overflow=0; data_avail=0, full=0, Iout=Qout=0.
//     Storage array not reset; outputs gated to 0 while empty so stale data is never visible.
//   - Reset mid-stream discards all entries immediately; no partial push/pop completes.
//   - Push = wr_en && (!full || pop). Writes mem[wr_ptr], wr_ptr += 1 mod DEPTH.
//   - Pop  = rd_en && data_avail. rd_ptr += 1 mod DEPTH. Consumer samples Iout/Qout in the
//     same cycle it sees rd_en && data_avail (matches filter shifting-state capture).
//   - Iout/Qout/data_avail/full/count are derived from registered state only (no rd_en/wr_en
//     combinational path to outputs). Write-to-read latency 1 cycle: push at edge N,
//     data_avail=1 and Iout/Qout valid from edge N onward.
//   - No empty bypass: wr_en while empty does not make data visible in the same cycle.
//   - Simultaneous push+pop: count unchanged; allowed when full (slot freed by pop is reused)
//     and when count==1 (head advances to the new entry, still data_avail=1).
//   - wr_en while full and no pop: data dropped, pointers/count unchanged, overflow <= 1.
//   - rd_en while empty: no effect (no underflow state; consumer simply waits).
//   - Pointers wrap DEPTH-1 -> 0; count tracks occupancy, full/empty never derived from ptr compare.
//   - flush (priority over wr_en/rd_en): pointers and count <= 0 next edge; overflow retained
//     (cleared only by reset); a wr_en in the flush cycle is discarded and does not set overflow.
//   - State: no FSM beyond pointer/count registers; count next = count + push - pop.
// TESTING
//   1. Reset, then wr_en one cycle with Iin=32'h00000257, Qin=32'hffffffd3 -> next cycle
//      data_avail=1, Iout=32'h00000257, Qout=32'hffffffd3, count=1; rd_en one cycle -> data_avail=0, Iout=Qout=0.
//   2. Push 16 entries I=k, Q=-k (k=1..16) -> full=1, count=16; 17th push -> overflow=1,
//      count=16; pop all 16 -> I sequence 1..16 exact, Q=-1..-16, entry 17 never appears.
//   3. Full FIFO, wr_en&&rd_en same cycle with I=99 -> count stays 16, overflow stays 0,
//      99 emerges after the 15 older entries.
//   4. Wrap: 40 push/pop pairs at count 1..3 -> pointers wrap twice, output order matches
//      input order, count never exceeds 3.
//   5. rd_en held high while empty, wr_en pulses every 4th cycle (filter-like) -> each
//      sample read exactly once, one cycle after its push; no pop while empty.
//   6. Assert reset asynchronously mid-cycle with count=5 -> outputs 0 immediately; flush with
//      count=7 and overflow=1 -> count=0 next edge, overflow still 1.

Source files
------------

// File: rtl/iq_stage_fifo.sv
// Complex I/Q sample FIFO between DSP stages: pulse-driven write side, show-ahead pull read side.
// The write side has no backpressure; a push against a full FIFO is dropped and flagged sticky.
module iq_stage_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          wr_en,
   input  logic [DATA_WIDTH-1:0]         Iin,
   input  logic [DATA_WIDTH-1:0]         Qin,
   input  logic                          rd_en,
   output logic [DATA_WIDTH-1:0]         Iout,
   output logic [DATA_WIDTH-1:0]         Qout,
   output logic                          data_avail,
   output logic                          full,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow
);

   localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH);
   localparam int unsigned COUNT_WIDTH = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0]  mem_i [DEPTH];
   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]  wr_ptr;
   logic [ADDR_WIDTH-1:0]  rd_ptr;
   logic [COUNT_WIDTH-1:0] count_q;
   logic                   overflow_q;

   logic                   pop;
   logic                   push;
   logic                   drop;

   // Status is derived only from registered occupancy; no enable reaches an output.
   assign data_avail = (count_q != '0);
   assign full       = (count_q == COUNT_WIDTH'(DEPTH));
   assign count      = count_q;
   assign overflow   = overflow_q;

   // Head is gated while empty so stale storage never appears on the outputs.
   assign Iout = data_avail ? mem_i[rd_ptr] : '0;
   assign Qout = data_avail ? mem_q[rd_ptr] : '0;

   // Flush overrides both sides; a pop frees the slot a full-time push reuses.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
      if (!flush) begin
         pop  = rd_en && data_avail;
         push = wr_en && (!full || pop);
         drop = wr_en && full && !pop;
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_i[wr_ptr] <= Iin;
         mem_q[wr_ptr] <= Qin;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= ADDR_WIDTH'(wr_ptr + 1'b1);
         if (pop)  rd_ptr <= ADDR_WIDTH'(rd_ptr + 1'b1);
         case ({push, pop})
            2'b10:   count_q <= COUNT_WIDTH'(count_q + 1'b1);
            2'b01:   count_q <= COUNT_WIDTH'(count_q - 1'b1);
            default: count_q <= count_q;
         endcase
         if (drop) overflow_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_iq_stage_fifo.sv
// Scoreboard bench for iq_stage_fifo: stimulus queues expected samples, a negedge monitor checks pops and status.
module tb_iq_stage_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic          wr_en = 1'b0;
   logic [DW-1:0] Iin   = '0;
   logic [DW-1:0] Qin   = '0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] Iout;
   logic [DW-1:0] Qout;
   logic          data_avail;
   logic          full;
   logic [4:0]    count;
   logic          overflow;

   iq_stage_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .flush(flush), .wr_en(wr_en),
      .Iin(Iin), .Qin(Qin), .rd_en(rd_en), .Iout(Iout), .Qout(Qout),
      .data_avail(data_avail), .full(full), .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   logic [2*DW-1:0] exp_q[$];
   logic            ovf_exp = 1'b0;
   int              n_pass  = 0;
   int              n_total = 0;
   int              max_cnt = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: status must match the scoreboard every cycle; a consumer pop consumes the queue head.
   always @(negedge clock) begin
      if (!reset) begin
         chk("data_avail", 32'(data_avail), 32'(exp_q.size() != 0));
         chk("count", 32'(count), 32'(exp_q.size()));
         chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(ovf_exp));
         if (32'(count) > max_cnt) max_cnt = 32'(count);
         if (data_avail && rd_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pop", 32'(1), 32'(0));
            end else begin
               chk("Iout", Iout, exp_q[0][2*DW-1:DW]);
               chk("Qout", Qout, exp_q[0][DW-1:0]);
               void'(exp_q.pop_front());
            end
         end else if (!data_avail) begin
            chk("Iout_empty", Iout, '0);
            chk("Qout_empty", Qout, '0);
         end
      end
   end

   // One clock of stimulus; the scoreboard is updated after the monitor has sampled this cycle.
   task automatic step(input logic w, input logic [DW-1:0] i, input logic [DW-1:0] q,
                       input logic r, input logic f);
      int   sz;
      logic p;
      logic acc;
      wr_en = w; Iin = i; Qin = q; rd_en = r; flush = f;
      sz  = exp_q.size();
      p   = r && (sz > 0) && !f;
      acc = w && !f && ((sz < DEPTH) || p);
      @(negedge clock); #1;
      if (f) exp_q.delete();
      else if (acc) exp_q.push_back({i, q});
      if (w && !acc && !f) ovf_exp = 1'b1;
      @(posedge clock); #1;
      wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      ovf_exp = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("reset_avail", 32'(data_avail), 32'(0));
      chk("reset_count", 32'(count), 32'(0));
      chk("reset_Iout", Iout, 32'h0);

      // 1: single push, visible next cycle, then popped
      step(1'b1, 32'h00000257, 32'hffffffd3, 1'b0, 1'b0);
      chk("t1_avail", 32'(data_avail), 32'(1));
      chk("t1_Iout", Iout, 32'h00000257);
      chk("t1_Qout", Qout, 32'hffffffd3);
      chk("t1_count", 32'(count), 32'(1));
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t1_avail_after", 32'(data_avail), 32'(0));
      chk("t1_Iout_after", Iout, 32'h0);
      chk("t1_Qout_after", Qout, 32'h0);

      // 2: fill, overflow, drain in order
      for (int k = 1; k <= 16; k++) step(1'b1, DW'(k), DW'(-k), 1'b0, 1'b0);
      chk("t2_full", 32'(full), 32'(1));
      chk("t2_count", 32'(count), 32'(16));
      step(1'b1, 32'd17, 32'hffffffef, 1'b0, 1'b0);
      chk("t2_overflow", 32'(overflow), 32'(1));
      chk("t2_count_ovf", 32'(count), 32'(16));
      for (int k = 1; k <= 16; k++) begin
         chk("t2_head_I", Iout, DW'(k));
         chk("t2_head_Q", Qout, DW'(-k));
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
      chk("t2_empty", 32'(data_avail), 32'(0));

      // 3: push+pop on a full FIFO
      do_reset();
      for (int k = 1; k <= 16; k++) step(1'b1, DW'(k), DW'(k), 1'b0, 1'b0);
      step(1'b1, 32'd99, 32'd99, 1'b1, 1'b0);
      chk("t3_count", 32'(count), 32'(16));
      chk("t3_overflow", 32'(overflow), 32'(0));
      for (int k = 2; k <= 16; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t3_last_I", Iout, 32'd99);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // 4: pointer wrap at low occupancy
      max_cnt = 0;
      step(1'b1, 32'd1000, 32'd2000, 1'b0, 1'b0);
      step(1'b1, 32'd1001, 32'd2001, 1'b0, 1'b0);
      for (int k = 0; k < 40; k++)
         step(1'b1, DW'(1002 + k), DW'(2002 + k), 1'b1, 1'b0);
      step(1'b1, 32'd1042, 32'd2042, 1'b0, 1'b0);
      chk("t4_count", 32'(count), 32'(3));
      for (int k = 0; k < 3; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t4_max_count", 32'(max_cnt), 32'(3));

      // 5: consumer always pulling, producer pulses every 4th cycle
      for (int k = 0; k < 24; k++)
         step(k % 4 == 0, DW'(300 + k), DW'(~k), 1'b1, 1'b0);
      chk("t5_drained", 32'(exp_q.size()), 32'(0));

      // 6a: async reset mid-cycle with 5 entries
      for (int k = 0; k < 5; k++) step(1'b1, DW'(50 + k), DW'(60 + k), 1'b0, 1'b0);
      chk("t6_count5", 32'(count), 32'(5));
      #2;
      reset = 1'b1;
      exp_q.delete();
      ovf_exp = 1'b0;
      #1;
      chk("t6_rst_avail", 32'(data_avail), 32'(0));
      chk("t6_rst_count", 32'(count), 32'(0));
      chk("t6_rst_Iout", Iout, 32'h0);
      chk("t6_rst_Qout", Qout, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      // 6b: flush at count 7 with overflow set; a flush-cycle write is discarded
      for (int k = 0; k < 17; k++) step(1'b1, DW'(70 + k), DW'(80 + k), 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t6_count7", 32'(count), 32'(7));
      chk("t6_ovf_before", 32'(overflow), 32'(1));
      step(1'b1, 32'hdead, 32'hbeef, 1'b0, 1'b1);
      chk("t6_flush_count", 32'(count), 32'(0));
      chk("t6_flush_ovf", 32'(overflow), 32'(1));
      chk("t6_flush_Iout", Iout, 32'h0);
      step(1'b1, 32'h0abc, 32'h0def, 1'b0, 1'b0);
      chk("t6_post_I", Iout, 32'h0abc);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("end_empty", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
